// File: rtl/mine_count_map.sv
// Scans a latched 5x5 mine mask in row-major order and streams one record per cell:
// index, mine flag and adjacent-mine count, then reports the total mine count.
module mine_count_map #(
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 5
) (
    input  logic                   in_clka,
    input  logic                   in_rst_n,
    input  logic                   in_start,
    input  logic [ROWS*COLS-1:0]   in_mines,
    input  logic                   in_ready,
    output logic                   out_busy,
    output logic                   out_valid,
    output logic [4:0]             out_index,
    output logic                   out_is_mine,
    output logic [3:0]             out_count,
    output logic [4:0]             out_total,
    output logic                   out_done
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IW    = 5;
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CELLS-1:0] mask, mask_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [RW-1:0]    row, row_nxt;
    logic [CW-1:0]    col, col_nxt;
    logic [4:0]       acc, acc_nxt;
    logic             busy_nxt, valid_nxt, is_mine_nxt, done_nxt;
    logic [4:0]       index_nxt, total_nxt;
    logic [3:0]       count_nxt;

    // Mines among the in-board neighbours of (r, c); no wrap between rows.
    function automatic logic [3:0] nbr_count(input logic [CELLS-1:0] m,
                                             input logic [RW-1:0]    r,
                                             input logic [CW-1:0]    c);
        logic [3:0]    n;
        logic [IW-1:0] k;
        int            rr;
        int            cc;
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(r) + dr;
                cc = int'(c) + dc;
                k  = '0;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < int'(ROWS) &&
                    cc >= 0 && cc < int'(COLS)) begin
                    k = IW'(rr * int'(COLS) + cc);
                    n = n + 4'(m[k]);
                end
            end
        end
        return n;
    endfunction

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        ptr_nxt     = ptr;
        row_nxt     = row;
        col_nxt     = col;
        acc_nxt     = acc;
        busy_nxt    = out_busy;
        valid_nxt   = out_valid;
        index_nxt   = out_index;
        is_mine_nxt = out_is_mine;
        count_nxt   = out_count;
        total_nxt   = out_total;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_start) begin
                    mask_nxt  = in_mines;
                    ptr_nxt   = '0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    acc_nxt   = '0;
                    total_nxt = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                valid_nxt   = 1'b1;
                index_nxt   = 5'(ptr);
                is_mine_nxt = mask[ptr];
                count_nxt   = nbr_count(mask, row, col);
                acc_nxt     = acc + 5'(mask[ptr]);
                state_nxt   = ST_HOLD;
            end
            ST_HOLD: begin
                if (in_ready) begin
                    valid_nxt = 1'b0;
                    if (ptr == IW'(CELLS - 1)) begin
                        done_nxt  = 1'b1;
                        total_nxt = acc;
                        state_nxt = ST_DONE;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                        if (col == CW'(COLS - 1)) begin
                            col_nxt = '0;
                            row_nxt = row + 1'b1;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                        state_nxt = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // All state advances on the falling edge of in_clka.
    always_ff @(negedge in_clka or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state       <= ST_IDLE;
            mask        <= '0;
            ptr         <= '0;
            row         <= '0;
            col         <= '0;
            acc         <= '0;
            out_busy    <= 1'b0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_is_mine <= 1'b0;
            out_count   <= '0;
            out_total   <= '0;
            out_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            mask        <= mask_nxt;
            ptr         <= ptr_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            acc         <= acc_nxt;
            out_busy    <= busy_nxt;
            out_valid   <= valid_nxt;
            out_index   <= index_nxt;
            out_is_mine <= is_mine_nxt;
            out_count   <= count_nxt;
            out_total   <= total_nxt;
            out_done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mine_count_map.sv
// Directed bench for mine_count_map: DUT updates on the falling edge, so the bench
// drives and samples on the rising edge.
module tb_mine_count_map;

    logic        in_clka = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic [24:0] in_mines = '0;
    logic        in_ready = 1'b1;
    logic        out_busy, out_valid, out_is_mine, out_done;
    logic [4:0]  out_index, out_total;
    logic [3:0]  out_count;

    int checks = 0;
    int failures = 0;

    int rec_idx [32];
    int rec_mine[32];
    int rec_cnt [32];
    int rec_cyc [32];
    int n_rec, n_done, total_seen, hold_bad, done_cyc;
    bit timed_out;

    localparam logic [24:0] M_CENTER = 25'h0001000;
    localparam logic [24:0] M_CORNER = 25'h0000030;
    localparam logic [24:0] M_FULL   = 25'h1FFFFFF;
    localparam logic [24:0] M_EMPTY  = 25'h0000000;
    localparam logic [24:0] M_MIXED  = 25'h0404001;

    logic [24:0] mask_tab [5] = '{M_CENTER, M_CORNER, M_FULL, M_EMPTY, M_MIXED};
    int total_tab [5] = '{1, 2, 25, 0, 3};
    int exp_tab [5][25] = '{
        '{0,0,0,0,0, 0,1,1,1,0, 0,1,0,1,0, 0,1,1,1,0, 0,0,0,0,0},
        '{1,1,0,1,0, 0,1,0,1,1, 1,1,0,0,0, 0,0,0,0,0, 0,0,0,0,0},
        '{3,5,5,5,3, 5,8,8,8,5, 5,8,8,8,5, 5,8,8,8,5, 3,5,5,5,3},
        '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0},
        '{0,1,0,0,0, 1,1,0,1,1, 0,0,0,1,0, 0,1,1,2,1, 0,1,0,1,0}
    };

    mine_count_map #(.ROWS(5), .COLS(5)) dut (
        .in_clka    (in_clka),
        .in_rst_n   (in_rst_n),
        .in_start   (in_start),
        .in_mines   (in_mines),
        .in_ready   (in_ready),
        .out_busy   (out_busy),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_is_mine(out_is_mine),
        .out_count  (out_count),
        .out_total  (out_total),
        .out_done   (out_done)
    );

    initial forever #5 in_clka = ~in_clka;

    task automatic start_scan(input logic [24:0] m);
        @(posedge in_clka);
        in_mines = m;
        in_start = 1'b1;
        @(posedge in_clka);
        in_start = 1'b0;
    endtask

    // Drives in_ready and records every accepted cell; optional stall and mid-scan start/mask change.
    task automatic collect(input int stall_idx, input int stall_cyc,
                           input int disturb_idx, input logic [24:0] disturb_mask);
        int stall_left = stall_cyc;
        bit held = 1'b0;
        bit done_seen = 1'b0;
        int h_idx = 0, h_mine = 0, h_cnt = 0;
        n_rec = 0; n_done = 0; total_seen = -1; hold_bad = 0; done_cyc = -1;
        timed_out = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rec_idx[i] = -1; rec_mine[i] = -1; rec_cnt[i] = -1; rec_cyc[i] = -1;
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge in_clka);
            in_start = 1'b0;
            if (done_seen && !out_busy) begin
                timed_out = 1'b0;
                break;
            end
            if (out_done) begin
                n_done++;
                total_seen = int'(out_total);
                done_cyc = c;
                done_seen = 1'b1;
                if (disturb_idx >= 0) in_start = 1'b1;
            end
            if (out_valid) begin
                if (int'(out_index) == disturb_idx) begin
                    in_mines = disturb_mask;
                    in_start = 1'b1;
                end
                if (int'(out_index) == stall_idx && stall_left > 0) begin
                    in_ready = 1'b0;
                    if (held && (int'(out_index) != h_idx || int'(out_is_mine) != h_mine ||
                                 int'(out_count) != h_cnt)) hold_bad++;
                    held = 1'b1;
                    h_idx = int'(out_index); h_mine = int'(out_is_mine); h_cnt = int'(out_count);
                    stall_left--;
                end else begin
                    in_ready = 1'b1;
                    if (held && int'(out_index) == stall_idx &&
                        (int'(out_is_mine) != h_mine || int'(out_count) != h_cnt)) hold_bad++;
                    if (n_rec < 32) begin
                        rec_idx[n_rec]  = int'(out_index);
                        rec_mine[n_rec] = int'(out_is_mine);
                        rec_cnt[n_rec]  = int'(out_count);
                        rec_cyc[n_rec]  = c;
                    end
                    n_rec++;
                end
            end else begin
                if (held && stall_left > 0) hold_bad++;
                in_ready = 1'b1;
            end
        end
        in_start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({out_busy, out_valid, out_index, out_is_mine, out_count, out_total, out_done} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b valid=%0b idx=%0d mine=%0b cnt=%0d tot=%0d done=%0b exp all 0",
                     out_busy, out_valid, out_index, out_is_mine, out_count, out_total, out_done);
        end
        @(posedge in_clka);
        in_rst_n = 1'b1;
        repeat (3) @(posedge in_clka);
        checks++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%0b valid=%0b exp 0 0", out_busy, out_valid);
        end
    endtask

    task automatic test_counts;
        logic [24:0] m;
        for (int p = 0; p < 5; p++) begin
            m = mask_tab[p];
            start_scan(m);
            checks++;
            if (out_busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL p%0d start_state got busy=%0b valid=%0b exp 1 0", p, out_busy, out_valid);
            end
            collect(-1, 0, -1, '0);
            checks++;
            if (timed_out || n_rec != 25 || n_done != 1) begin
                failures++;
                $display("FAIL p%0d scan_shape got timeout=%0b records=%0d dones=%0d exp 0 25 1",
                         p, timed_out, n_rec, n_done);
            end
            checks++;
            if (rec_cyc[0] != 0) begin
                failures++;
                $display("FAIL p%0d first_latency got cyc=%0d exp 0", p, rec_cyc[0]);
            end
            for (int i = 0; i < 25; i++) begin
                checks++;
                if (rec_idx[i] != i || rec_mine[i] != int'(m[i]) || rec_cnt[i] != exp_tab[p][i]) begin
                    failures++;
                    $display("FAIL p%0d record%0d got idx=%0d mine=%0d cnt=%0d exp idx=%0d mine=%0d cnt=%0d",
                             p, i, rec_idx[i], rec_mine[i], rec_cnt[i], i, int'(m[i]), exp_tab[p][i]);
                end
            end
            checks++;
            if (total_seen != total_tab[p] || done_cyc != rec_cyc[24] + 1) begin
                failures++;
                $display("FAIL p%0d total_done got total=%0d done_cyc=%0d exp total=%0d done_cyc=%0d",
                         p, total_seen, done_cyc, total_tab[p], rec_cyc[24] + 1);
            end
            @(posedge in_clka);
            checks++;
            if (int'(out_total) != total_tab[p] || out_busy !== 1'b0 || out_done !== 1'b0) begin
                failures++;
                $display("FAIL p%0d total_hold got total=%0d busy=%0b done=%0b exp %0d 0 0",
                         p, out_total, out_busy, out_done, total_tab[p]);
            end
        end
    endtask

    task automatic test_backpressure;
        start_scan(M_MIXED);
        collect(7, 10, -1, '0);
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL bp_hold_stable got changes=%0d exp 0", hold_bad);
        end
        checks++;
        if (rec_cyc[7] - rec_cyc[6] != 12 || rec_cyc[8] - rec_cyc[7] != 2) begin
            failures++;
            $display("FAIL bp_timing got gap67=%0d gap78=%0d exp 12 2",
                     rec_cyc[7] - rec_cyc[6], rec_cyc[8] - rec_cyc[7]);
        end
        checks++;
        if (timed_out || n_rec != 25 || n_done != 1 || total_seen != 3) begin
            failures++;
            $display("FAIL bp_shape got timeout=%0b records=%0d dones=%0d total=%0d exp 0 25 1 3",
                     timed_out, n_rec, n_done, total_seen);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (rec_idx[i] != i || rec_cnt[i] != exp_tab[4][i]) begin
                failures++;
                $display("FAIL bp_record%0d got idx=%0d cnt=%0d exp idx=%0d cnt=%0d",
                         i, rec_idx[i], rec_cnt[i], i, exp_tab[4][i]);
            end
        end
    endtask

    task automatic test_start_busy;
        logic [24:0] m = M_CORNER;
        start_scan(m);
        collect(-1, 0, 10, M_FULL);
        checks++;
        if (timed_out || n_rec != 25 || n_done != 1 || total_seen != 2) begin
            failures++;
            $display("FAIL busy_shape got timeout=%0b records=%0d dones=%0d total=%0d exp 0 25 1 2",
                     timed_out, n_rec, n_done, total_seen);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (rec_idx[i] != i || rec_mine[i] != int'(m[i]) || rec_cnt[i] != exp_tab[1][i]) begin
                failures++;
                $display("FAIL busy_record%0d got idx=%0d mine=%0d cnt=%0d exp idx=%0d mine=%0d cnt=%0d",
                         i, rec_idx[i], rec_mine[i], rec_cnt[i], i, int'(m[i]), exp_tab[1][i]);
            end
        end
        repeat (3) @(posedge in_clka);
        checks++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done_ignored got busy=%0b valid=%0b exp 0 0", out_busy, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        bit extra = 1'b0;
        start_scan(M_MIXED);
        in_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge in_clka);
            if (out_valid && out_index == 5'd13) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_reach_13 got found=0 exp 1");
        end
        in_rst_n = 1'b0;
        #1;
        checks++;
        if ({out_busy, out_valid, out_index, out_is_mine, out_count, out_total, out_done} !== 18'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got busy=%0b valid=%0b idx=%0d mine=%0b cnt=%0d tot=%0d done=%0b exp all 0",
                     out_busy, out_valid, out_index, out_is_mine, out_count, out_total, out_done);
        end
        @(posedge in_clka);
        in_rst_n = 1'b1;
        repeat (6) begin
            @(posedge in_clka);
            if (out_done || out_busy || out_valid) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL rst_no_done got activity=1 exp 0");
        end
        start_scan(M_CENTER);
        collect(-1, 0, -1, '0);
        checks++;
        if (timed_out || n_rec != 25 || n_done != 1 || total_seen != 1) begin
            failures++;
            $display("FAIL rst_rescan_shape got timeout=%0b records=%0d dones=%0d total=%0d exp 0 25 1 1",
                     timed_out, n_rec, n_done, total_seen);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (rec_idx[i] != i || rec_mine[i] != int'(i == 12) || rec_cnt[i] != exp_tab[0][i]) begin
                failures++;
                $display("FAIL rst_record%0d got idx=%0d mine=%0d cnt=%0d exp idx=%0d mine=%0d cnt=%0d",
                         i, rec_idx[i], rec_mine[i], rec_cnt[i], i, int'(i == 12), exp_tab[0][i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_counts;
        test_backpressure;
        test_start_busy;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
